// File: rtl/dot36_feeder.sv
// Streaming front end for the 36-element dot-product engine: packs operand pairs into
// the engine's two operand vectors, tracks in-flight vectors and returns scalar results.
`ifndef DOT36_DATA_LEN
`define DOT36_DATA_LEN 16
`endif

module dot36_feeder #(
   parameter int DATA_LEN = `DOT36_DATA_LEN,
   parameter int N        = 36,
   parameter int LAT      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_LEN-1:0]   in_a,
   input  logic [DATA_LEN-1:0]   in_b,
   output logic                  eng_load,
   output logic [N*DATA_LEN-1:0] eng_d1,
   output logic [N*DATA_LEN-1:0] eng_d2,
   input  logic [DATA_LEN-1:0]   eng_q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_LEN-1:0]   out_data
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   logic [IDX_W-1:0] idx;
   logic             full;
   logic [LAT-1:0]   tag;
   logic             slot_free;
   logic             stall;
   logic             accept;
   logic             issue;
   logic             capture;

   // The engine freezes whenever a finished result has nowhere to go.
   assign slot_free = ~out_valid | out_ready;
   assign stall     = tag[LAT-1] & ~slot_free;
   assign eng_load  = ~stall & (full | (|tag));
   assign in_ready  = ~full | eng_load;
   assign accept    = in_valid & in_ready;
   assign issue     = full & eng_load;
   assign capture   = tag[LAT-1] & slot_free;

   // Slot 0 of the next vector may be written on the issue edge; the engine sees pre-edge data.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         full   <= 1'b0;
         eng_d1 <= '0;
         eng_d2 <= '0;
      end else begin
         if (accept) begin
            eng_d1[int'(idx)*DATA_LEN +: DATA_LEN] <= in_a;
            eng_d2[int'(idx)*DATA_LEN +: DATA_LEN] <= in_b;
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
         full <= (full & ~issue) | (accept & (idx == LAST_IDX));
      end
   end

   // Tag pipeline shifts with the engine; the output register captures results when free.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (eng_load) begin
            tag[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
               tag[i] <= tag[i-1];
            end
         end
         if (capture) begin
            out_valid <= 1'b1;
            out_data  <= eng_q;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
